// File: rtl/ai_accelerator_pkg.sv
// Shared widths for the conv2d accelerator and its scheduler.
package ai_accelerator_pkg;
   localparam int unsigned DATA_WIDTH   = 8;
   localparam int unsigned RESULT_WIDTH = 2 * DATA_WIDTH + 4;
   localparam int unsigned FILTER_SIZE  = 3;
endpackage

// File: rtl/conv2d_window_scheduler_if.sv
// Pixel input stream and tagged result stream of conv2d_window_scheduler.
interface conv2d_window_scheduler_if #(
   parameter int unsigned IMG_WIDTH  = 8,
   parameter int unsigned IMG_HEIGHT = 8
);
   import ai_accelerator_pkg::*;

   logic                          pix_valid;
   logic                          pix_ready;
   logic [DATA_WIDTH-1:0]         pix_data;
   logic                          res_valid;
   logic                          res_ready;
   logic [RESULT_WIDTH:0]         res_data;
   logic [$clog2(IMG_HEIGHT)-1:0] res_row;
   logic [$clog2(IMG_WIDTH)-1:0]  res_col;

   modport master (
      output pix_valid, pix_data, res_ready,
      input  pix_ready, res_valid, res_data, res_row, res_col
   );

   modport slave (
      input  pix_valid, pix_data, res_ready,
      output pix_ready, res_valid, res_data, res_row, res_col
   );
endinterface

// File: rtl/conv2d_window_scheduler.sv
// Frame sequencer: line-buffers a pixel stream into 3x3 windows for the accelerator and queues tagged results.
// Defining CONV_SCHED_PERF_EN adds the stall_cnt output.
module conv2d_window_scheduler
   import ai_accelerator_pkg::*;
#(
   parameter int unsigned IMG_WIDTH   = 8,
   parameter int unsigned IMG_HEIGHT  = 8,
   parameter int unsigned ACC_LATENCY = 1
) (
   input  logic                                                  clk,
   input  logic                                                  rst,
   input  logic                                                  start,
   output logic                                                  busy,
   output logic                                                  done,
   input  logic                                                  filt_we,
   input  logic [3:0]                                            filt_addr,
   input  logic [DATA_WIDTH-1:0]                                 filt_data,
   output logic [FILTER_SIZE-1:0][FILTER_SIZE-1:0][DATA_WIDTH-1:0] acc_filter,
   output logic [FILTER_SIZE-1:0][FILTER_SIZE-1:0][DATA_WIDTH-1:0] acc_patch,
   input  logic [RESULT_WIDTH:0]                                 acc_result,
`ifdef CONV_SCHED_PERF_EN
   output logic [31:0]                                           stall_cnt,
`endif
   conv2d_window_scheduler_if.slave                              io
);
   localparam int unsigned ROW_W = $clog2(IMG_HEIGHT);
   localparam int unsigned COL_W = $clog2(IMG_WIDTH);
   localparam int unsigned DEPTH = ACC_LATENCY + 2;
   localparam int unsigned NTAP  = ACC_LATENCY + 1;
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;
   state_t state;

   logic [ROW_W-1:0]                                      row;
   logic [COL_W-1:0]                                      col;
   logic [DATA_WIDTH-1:0]                                 lb0 [IMG_WIDTH];
   logic [DATA_WIDTH-1:0]                                 lb1 [IMG_WIDTH];
   logic [FILTER_SIZE-1:0][FILTER_SIZE-1:0][DATA_WIDTH-1:0] win;

   logic [NTAP-1:0]        tag_vld;
   logic [ROW_W-1:0]       tag_row [NTAP];
   logic [COL_W-1:0]       tag_col [NTAP];

   logic [RESULT_WIDTH:0]  fifo_data [DEPTH];
   logic [ROW_W-1:0]       fifo_row  [DEPTH];
   logic [COL_W-1:0]       fifo_col  [DEPTH];
   logic [PTR_W-1:0]       wr_ptr, rd_ptr;
   logic [CNT_W-1:0]       fifo_cnt, fifo_cnt_nxt;
   logic [CNT_W-1:0]       inflight, inflight_nxt;

   logic pix_ok, res_ok, pix_hs, res_hs, last_pix, win_done, push;

   always_comb begin
      inflight = '0;
      for (int unsigned i = 0; i < NTAP; i++) begin
         inflight = inflight + CNT_W'(tag_vld[i]);
      end
      // Credit covers both the accelerator pipeline and the FIFO, so a push never finds it full.
      pix_ok       = (state == STREAM) && (32'(inflight) + 32'(fifo_cnt) < DEPTH);
      res_ok       = (fifo_cnt != '0);
      pix_hs       = io.pix_valid && pix_ok;
      res_hs       = res_ok && io.res_ready;
      last_pix     = pix_hs && (row == ROW_W'(IMG_HEIGHT - 1)) && (col == COL_W'(IMG_WIDTH - 1));
      win_done     = pix_hs && (row >= ROW_W'(2)) && (col >= COL_W'(2));
      push         = tag_vld[NTAP-1];
      inflight_nxt = inflight - CNT_W'(push) + CNT_W'(win_done);
      fifo_cnt_nxt = fifo_cnt + CNT_W'(push) - CNT_W'(res_hs);
   end

   always_comb begin
      io.pix_ready = pix_ok;
      io.res_valid = res_ok;
      io.res_data  = fifo_data[rd_ptr];
      io.res_row   = fifo_row[rd_ptr];
      io.res_col   = fifo_col[rd_ptr];
   end

   // Leaving DRAIN looks at next-cycle counts so done follows the last result handshake directly.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (start) begin
               state <= STREAM;
               busy  <= 1'b1;
            end
            STREAM: if (last_pix) state <= DRAIN;
            DRAIN: if (inflight_nxt == '0 && fifo_cnt_nxt == '0) begin
               state <= DONE;
               done  <= 1'b1;
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_filter <= '0;
      end else if (state == IDLE && filt_we) begin
         for (int unsigned r = 0; r < FILTER_SIZE; r++) begin
            for (int unsigned c = 0; c < FILTER_SIZE; c++) begin
               if (filt_addr == 4'(r * FILTER_SIZE + c)) acc_filter[r][c] <= filt_data;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         row       <= '0;
         col       <= '0;
         win       <= '0;
         acc_patch <= '0;
         for (int unsigned i = 0; i < IMG_WIDTH; i++) begin
            lb0[i] <= '0;
            lb1[i] <= '0;
         end
      end else if (state == IDLE && start) begin
         row <= '0;
         col <= '0;
      end else if (pix_hs) begin
         if (col == COL_W'(IMG_WIDTH - 1)) begin
            col <= '0;
            row <= (row == ROW_W'(IMG_HEIGHT - 1)) ? '0 : row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
         lb0[col] <= io.pix_data;
         lb1[col] <= lb0[col];
         for (int unsigned r = 0; r < FILTER_SIZE; r++) begin
            win[r][0] <= win[r][1];
            win[r][1] <= win[r][2];
         end
         win[0][2] <= lb1[col];
         win[1][2] <= lb0[col];
         win[2][2] <= io.pix_data;
         if (win_done) begin
            for (int unsigned r = 0; r < FILTER_SIZE; r++) begin
               acc_patch[r][0] <= win[r][1];
               acc_patch[r][1] <= win[r][2];
            end
            acc_patch[0][2] <= lb1[col];
            acc_patch[1][2] <= lb0[col];
            acc_patch[2][2] <= io.pix_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tag_vld <= '0;
         for (int unsigned i = 0; i < NTAP; i++) begin
            tag_row[i] <= '0;
            tag_col[i] <= '0;
         end
      end else begin
         tag_vld[0] <= win_done;
         tag_row[0] <= row - ROW_W'(2);
         tag_col[0] <= col - COL_W'(2);
         for (int unsigned i = 1; i < NTAP; i++) begin
            tag_vld[i] <= tag_vld[i-1];
            tag_row[i] <= tag_row[i-1];
            tag_col[i] <= tag_col[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            fifo_data[i] <= '0;
            fifo_row[i]  <= '0;
            fifo_col[i]  <= '0;
         end
      end else begin
         if (push) begin
            fifo_data[wr_ptr] <= acc_result;
            fifo_row[wr_ptr]  <= tag_row[NTAP-1];
            fifo_col[wr_ptr]  <= tag_col[NTAP-1];
            wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         end
         if (res_hs) rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         fifo_cnt <= fifo_cnt_nxt;
      end
   end

`ifdef CONV_SCHED_PERF_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= '0;
      end else if (state == IDLE && start) begin
         stall_cnt <= '0;
      end else if ((state == STREAM || state == DRAIN) &&
                   ((io.pix_valid && !pix_ok) || (res_ok && !io.res_ready)) &&
                   stall_cnt != '1) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_conv2d_window_scheduler.sv
// Directed bench: 3x3 and 4x4 scheduler instances, each with a behavioural accelerator of latency 1.
module tb_conv2d_window_scheduler;
   import ai_accelerator_pkg::*;

   localparam int unsigned LAT = 1;
   localparam int unsigned RW  = RESULT_WIDTH + 1;
   typedef logic [RW-1:0] res_t;
   typedef logic [FILTER_SIZE-1:0][FILTER_SIZE-1:0][DATA_WIDTH-1:0] fmat_t;

   typedef struct packed {
      logic             big;
      logic             inj;
      logic [0:8][7:0]  filt;
      logic [7:0]       pix0;
      logic [7:0]       pstep;
      logic [0:3][31:0] exp;
      logic [7:0]       hold;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic       big = 1'b0, st = 1'b0, pv = 1'b0, rr = 1'b1, fw = 1'b0;
   logic [3:0] fa = '0;
   logic [7:0] fd = '0, pd = '0;

   int checks = 0, errors = 0, cyc = 0;
   int last_pix_cyc, first_rv, npix, got, early;
   vec_t vecs [6];

   always @(posedge clk) cyc <= cyc + 1;

   conv2d_window_scheduler_if #(.IMG_WIDTH(3), .IMG_HEIGHT(3)) if3 ();
   conv2d_window_scheduler_if #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) if4 ();

   logic  busy3, done3, busy4, done4;
   fmat_t filt3, patch3, filt4, patch4;
   res_t  accr3, accr4;

   assign if3.pix_valid = !big && pv;
   assign if3.pix_data  = pd;
   assign if3.res_ready = !big && rr;
   assign if4.pix_valid = big && pv;
   assign if4.pix_data  = pd;
   assign if4.res_ready = big && rr;

   conv2d_window_scheduler #(.IMG_WIDTH(3), .IMG_HEIGHT(3), .ACC_LATENCY(LAT)) u_dut3 (
      .clk(clk), .rst(rst), .start(!big && st), .busy(busy3), .done(done3),
      .filt_we(fw), .filt_addr(fa), .filt_data(fd),
      .acc_filter(filt3), .acc_patch(patch3), .acc_result(accr3), .io(if3));

   conv2d_window_scheduler #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .ACC_LATENCY(LAT)) u_dut4 (
      .clk(clk), .rst(rst), .start(big && st), .busy(busy4), .done(done4),
      .filt_we(fw), .filt_addr(fa), .filt_data(fd),
      .acc_filter(filt4), .acc_patch(patch4), .acc_result(accr4), .io(if4));

   function automatic res_t dot(input fmat_t f, input fmat_t p);
      res_t s = '0;
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            s = s + res_t'(f[r][c]) * res_t'(p[r][c]);
      return s;
   endfunction

   // Accelerator stand-in: one register stage
   always @(posedge clk) begin
      accr3 <= dot(filt3, patch3);
      accr4 <= dot(filt4, patch4);
   end

   logic       pr, rv, bsy, dn;
   res_t       rd;
   logic [1:0] rrow, rcol;
   fmat_t      patch, filt;
   assign pr    = big ? if4.pix_ready : if3.pix_ready;
   assign rv    = big ? if4.res_valid : if3.res_valid;
   assign rd    = big ? if4.res_data  : if3.res_data;
   assign rrow  = big ? if4.res_row   : if3.res_row;
   assign rcol  = big ? if4.res_col   : if3.res_col;
   assign bsy   = big ? busy4 : busy3;
   assign dn    = big ? done4 : done3;
   assign patch = big ? patch4 : patch3;
   assign filt  = big ? filt4 : filt3;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic wr_filt(input logic [3:0] a, input logic [7:0] d);
      @(posedge clk); #1;
      fw = 1'b1; fa = a; fd = d;
      @(posedge clk); #1;
      fw = 1'b0;
   endtask

   task automatic load_filt(input vec_t v);
      bit ok;
      for (int k = 0; k < 9; k++) begin
         wr_filt(4'(k), v.filt[k]);
         @(negedge clk);
         chk("filt_write", filt[k/3][k%3], v.filt[k]);
      end
      wr_filt(4'd12, 8'hAA);
      @(negedge clk);
      ok = 1'b1;
      for (int k = 0; k < 9; k++) if (filt[k/3][k%3] != v.filt[k]) ok = 1'b0;
      chk("filt_addr_gt8", ok, 1);
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 st = 1'b1;
      @(posedge clk); #1 st = 1'b0;
   endtask

   task automatic send_pix(input logic [7:0] d, output bit ok);
      pv = 1'b1; pd = d; ok = 1'b0;
      for (int n = 0; n < 200 && !ok; n++) begin
         @(negedge clk);
         if (pr) begin ok = 1'b1; last_pix_cyc = cyc; end
         @(posedge clk); #1;
      end
   endtask

   task automatic run_frame(input vec_t v);
      int w, nres, post;
      big = v.big;
      w = v.big ? 4 : 3;
      nres = (w - 2) * (w - 2);
      load_filt(v);
      got = 0; early = 0; first_rv = -1; last_pix_cyc = -1; npix = 0;
      pulse_start();
      fork
         begin
            bit ok;
            for (int i = 0; i < w * w; i++) begin
               if (v.inj && i == 5) begin fw = 1'b1; fa = 4'd4; fd = 8'd7; st = 1'b1; end
               send_pix(8'(int'(v.pix0) + i * int'(v.pstep)), ok);
               fw = 1'b0; st = 1'b0;
               if (!ok) begin chk("pix_timeout", 0, 1); break; end
               npix++;
            end
            pv = 1'b0;
         end
         begin
            int k = 0;
            rr = (v.hold == 0);
            while (got < nres && k < 300) begin
               @(negedge clk);
               if (dn) early++;
               if (v.hold != 0 && k == int'(v.hold)) begin
                  chk("bp_pix_ready", pr, 0);
                  chk("bp_accepted", npix, w * w - 1);
                  chk("bp_res_valid", rv, 1);
                  rr = 1'b1;
               end
               if (rv && first_rv < 0) first_rv = cyc;
               if (rv && rr) begin
                  chk("res_data", rd, v.exp[got]);
                  chk("res_row", rrow, got / (w - 2));
                  chk("res_col", rcol, got % (w - 2));
                  got++;
               end
               @(posedge clk);
               k++;
            end
         end
      join
      chk("res_count", got, nres);
      post = 0;
      for (int n = 0; n < 4; n++) begin
         @(negedge clk);
         if (n == 0) chk("done_timing", dn, 1);
         if (dn) post++;
      end
      chk("done_pulses", early + post, 1);
      chk("busy_idle", bsy, 0);
      if (!v.big) chk("acc_latency", first_rv - last_pix_cyc, LAT + 2);
      rr = 1'b1;
   endtask

   initial begin
      fmat_t ep;
      bit ok;
      int nd;

      vecs[0] = '{big:1'b0, inj:1'b0, filt:{8'd1,8'd0,8'd1,8'd2,8'd0,8'd2,8'd1,8'd0,8'd1},
                  pix0:8'd10, pstep:8'd10, exp:{32'd400,32'd0,32'd0,32'd0}, hold:8'd0};
      vecs[1] = '{big:1'b0, inj:1'b0, filt:{9{8'd255}},
                  pix0:8'd255, pstep:8'd0, exp:{32'd585225,32'd0,32'd0,32'd0}, hold:8'd0};
      vecs[2] = '{big:1'b1, inj:1'b1, filt:{9{8'd1}},
                  pix0:8'd1, pstep:8'd0, exp:{32'd9,32'd9,32'd9,32'd9}, hold:8'd0};
      vecs[3] = '{big:1'b1, inj:1'b0, filt:{9{8'd1}},
                  pix0:8'd1, pstep:8'd0, exp:{32'd9,32'd9,32'd9,32'd9}, hold:8'd20};
      vecs[4] = '{big:1'b1, inj:1'b0, filt:{8'd0,8'd0,8'd0,8'd0,8'd1,8'd0,8'd0,8'd0,8'd0},
                  pix0:8'd1, pstep:8'd1, exp:{32'd6,32'd7,32'd10,32'd11}, hold:8'd0};
      vecs[5] = '{big:1'b1, inj:1'b0, filt:{8'd2,8'd0,8'd0,8'd0,8'd0,8'd0,8'd0,8'd0,8'd0},
                  pix0:8'd1, pstep:8'd1, exp:{32'd2,32'd4,32'd10,32'd12}, hold:8'd0};

      #11;
      chk("rst_busy", busy3 | busy4, 0);
      chk("rst_done", done3 | done4, 0);
      chk("rst_pix_ready", if3.pix_ready | if4.pix_ready, 0);
      chk("rst_res_valid", if3.res_valid | if4.res_valid, 0);
      chk("rst_res_data", if3.res_data | if4.res_data, 0);
      chk("rst_filter", (filt3 == '0) && (filt4 == '0), 1);
      chk("rst_patch", (patch3 == '0) && (patch4 == '0), 1);
      #2 rst = 1'b1;

      for (int i = 0; i < 6; i++) run_frame(vecs[i]);

      // Mid-frame reset: window registers still hold the last window of the ramp frame
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            ep[r][c] = 8'(1 + 4 * (r + 1) + (c + 1));
      big = 1'b1;
      pulse_start();
      for (int i = 0; i < 6; i++) begin
         send_pix(8'd1, ok);
         if (!ok) chk("rst_pix_timeout", 0, 1);
      end
      @(negedge clk);
      chk("pre_rst_busy", bsy, 1);
      chk("pre_rst_patch", patch == ep, 1);
      #2 rst = 1'b0;
      #1;
      chk("async_busy", bsy, 0);
      chk("async_pix_ready", pr, 0);
      chk("async_res_valid", rv, 0);
      chk("async_patch", patch == '0, 1);
      pv = 1'b0;
      @(posedge clk); @(posedge clk); #3 rst = 1'b1;
      nd = 0;
      for (int n = 0; n < 5; n++) begin
         @(negedge clk);
         if (dn) nd++;
      end
      chk("rst_no_done", nd, 0);
      run_frame(vecs[2]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout got 0 want 1");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/conv2d_window_scheduler.md
# conv2d_window_scheduler

Frame-level sequencer for `accelerator_for_conv2d`. It holds the 3x3 filter loaded through a register-write port and accepts an image as a raster-order pixel stream using valid/ready. It builds every valid 3x3 window with two line buffers and presents each window to the accelerator. Results are collected into a small output FIFO and returned on a valid/ready result stream, tagged with the window coordinates.

## Interface
- `IMG_WIDTH`, default 8, pixels per row (≥3).
- `IMG_HEIGHT`, default 8, rows per frame (≥3).
- `ACC_LATENCY`, default 1, clock edges from `acc_patch` update to `acc_result` being valid.
- `DATA_WIDTH`, `RESULT_WIDTH`, `FILTER_SIZE` (=3) are taken from `ai_accelerator_pkg`.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  pulse in IDLE begins a frame.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at frame completion.
- `filt_we`  in  1  filter write strobe.
- `filt_addr`  in  4  coefficient index 0..8, raster order (row*3+col).
- `filt_data`  in  DATA_WIDTH  coefficient value.
- `pix_valid`  in  1  pixel offered.
- `pix_ready`  out  1  pixel accepted when valid && ready.
- `pix_data`  in  DATA_WIDTH  pixel value.
- `acc_filter`  out  [3][3]xDATA_WIDTH  drives the accelerator `filter_matrix`.
- `acc_patch`  out  [3][3]xDATA_WIDTH  drives the accelerator `image_patch`.
- `acc_result`  in  RESULT_WIDTH+1  the accelerator `result`.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  result consumed when valid && ready.
- `res_data`  out  RESULT_WIDTH+1  convolution sum, passed unmodified.
- `res_row`, `res_col`  out  $clog2(IMG_HEIGHT), $clog2(IMG_WIDTH)  top-left coordinate of the window.

## Operation
- FSM states: IDLE, STREAM, DRAIN, DONE.
  - IDLE -> STREAM when `start` is high.
  - STREAM -> DRAIN on the handshake of pixel (IMG_HEIGHT-1, IMG_WIDTH-1).
  - DRAIN -> DONE when the in-flight count is 0 and the FIFO is empty.
  - DONE -> IDLE unconditionally after one cycle; `done` is high in DONE.
- `start` is ignored outside IDLE.
- Filter writes:
  - Accepted only in IDLE.
  - `filt_we` is ignored in other states.
  - Writes with `filt_addr` > 8 are ignored.
  - `acc_filter` is driven directly from the coefficient registers.
- Pixels:
  - Row and column counters advance on each handshake; the column wraps at IMG_WIDTH-1 and increments the row.
  - Two line buffers of IMG_WIDTH entries and a 3x3 shift window are maintained.
- A window is complete when the accepted pixel has row ≥2 and col ≥2.
  - The window is registered into `acc_patch`.
  - Tag (row-2, col-2) enters a tag pipeline of length ACC_LATENCY+1.
- The tag pipeline output writes `acc_result` and the tag into the output FIFO. FIFO depth is DEPTH = ACC_LATENCY+2; the FIFO has no bypass.
- Credit rule: `pix_ready` = (state==STREAM) && (inflight + fifo_count < DEPTH). No result is ever dropped.
- Each frame emits exactly (IMG_HEIGHT-2)*(IMG_WIDTH-2) results, in raster order.
- Reset values: all outputs 0, including `acc_filter`/`acc_patch` (coefficient and window registers cleared). State = IDLE, counters = 0, FIFO empty.
- Reset asserted mid-frame aborts the frame immediately. Nothing is flushed and there is no `done` pulse.

## Timing
- Completing pixel accepted in cycle t:
  - `acc_patch` is valid from cycle t+1.
  - `acc_result` is sampled at the edge ending cycle t+1+ACC_LATENCY.
  - `res_valid` is high from cycle t+ACC_LATENCY+2, provided the FIFO was empty.
- `res_valid` and `res_data` hold stable while `res_ready` is low.
- `done` rises in the cycle after the last result handshake.
- A filter write in cycle t is visible on `acc_filter` from cycle t+1.
- Simultaneous FIFO push and pop keeps occupancy unchanged. Push into a full FIFO cannot occur because of the credit rule.

## Configuration
- `CONV_SCHED_PERF_EN` defined:
  - Adds output port `stall_cnt` (32 bits).
  - Counts cycles in STREAM/DRAIN with (`pix_valid` && !`pix_ready`) || (`res_valid` && !`res_ready`).
  - Clears on `start`; saturates at all-ones; reset value 0.
- `CONV_SCHED_PERF_EN` undefined: the port and counter do not exist, and the block is otherwise identical.

## Test plan
- All-ones 3x3 filter, 4x4 image of 1s, `res_ready`=1:
  - Exactly 4 results of 9, at coordinates (0,0),(0,1),(1,0),(1,1).
  - `done` pulses once.
- IMG 3x3, filter {1,0,1;2,0,2;1,0,1}, pixels 10,20,...,90:
  - Single result 400 at (0,0).
  - `res_valid` exactly ACC_LATENCY+2 cycles after the last pixel handshake.
- IMG 3x3, filter and pixels all 255 -> result 585225 with no truncation.
- 4x4 all 1s with `res_ready` held low for 20 cycles:
  - `pix_ready` deasserts once occupancy plus in-flight reaches ACC_LATENCY+2.
  - After release, all 4 results of 9 arrive in order with none lost.
- Reset asserted after 6 pixels:
  - `busy`, `pix_ready`, `res_valid` and `acc_patch` go to 0 without waiting for a clock edge.
  - After reload and `start`, a clean frame produces correct results.
- `filt_we` with value 7 and a second `start` issued during STREAM -> both ignored; results match the original filter.
